// File: rtl/decode_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, ALU_op encodings,
// opcode-class enum, control bundle and the XZR index helper.
package decode_pkg;

  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;

  localparam logic [1:0] ALU_LDST  = 2'b00;
  localparam logic [1:0] ALU_CBZ   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_B,
    CLS_CBZ,
    CLS_LDUR,
    CLS_STUR,
    CLS_RTYPE
  } op_class_e;

  typedef struct packed {
    logic       uncond_branch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic int unsigned xzr_idx(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

  // Classify from instr[31:21]; earlier matches take precedence.
  function automatic op_class_e op_class(input logic [10:0] opc);
    op_class_e cls;
    cls = CLS_NONE;
    if (opc[10:5] == OP_B)                         cls = CLS_B;
    else if (opc[10:3] == OP_CBZ)                  cls = CLS_CBZ;
    else if (opc == OP_LDUR)                       cls = CLS_LDUR;
    else if (opc == OP_STUR)                       cls = CLS_STUR;
    else if (opc == OP_ADD || opc == OP_SUB ||
             opc == OP_AND || opc == OP_ORR)       cls = CLS_RTYPE;
    return cls;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file; the top index (XZR) reads zero and ignores writes.
// DECODE_WB_BYPASS_EN: a same-cycle write is forwarded to matching reads.
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter  int unsigned WORD     = 64,
  parameter  int unsigned NUM_REGS = 32,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WORD-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [WORD-1:0] rd_data1_c,
  output logic [WORD-1:0] rd_data2_c
);

  // XZR has no storage; out-of-range indices match no entry.
  localparam int unsigned NSTORE = xzr_idx(NUM_REGS);

  logic [WORD-1:0] mem_q [NSTORE];
  logic [WORD-1:0] mem_d [NSTORE];

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < NSTORE; i++) begin
      if (wr_en && wr_addr == AW'(i)) mem_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSTORE; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data1_c = '0;
    rd_data2_c = '0;
    for (int unsigned i = 0; i < NSTORE; i++) begin
      if (rd_addr1 == AW'(i)) rd_data1_c = mem_q[i];
      if (rd_addr2 == AW'(i)) rd_data2_c = mem_q[i];
    end
`ifdef DECODE_WB_BYPASS_EN
    for (int unsigned i = 0; i < NSTORE; i++) begin
      if (wr_en && wr_addr == AW'(i)) begin
        if (rd_addr1 == AW'(i)) rd_data1_c = wr_data;
        if (rd_addr2 == AW'(i)) rd_data2_c = wr_data;
      end
    end
`endif
  end

endmodule

// File: rtl/decode_pipe.sv
// LEGv8 decode stage with valid/ready handshakes, write-back register file and
// load-use stall; output register is ID/EX. Option macro: DECODE_WB_BYPASS_EN.
module decode_pipe
  import decode_pkg::*;
#(
  parameter  int unsigned WORD      = 64,
  parameter  int unsigned INSTR_LEN = 32,
  parameter  int unsigned NUM_REGS  = 32,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [WORD-1:0]      in_pc,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [WORD-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_opcode,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_read_data1,
  output logic [WORD-1:0]      out_read_data2,
  output logic [WORD-1:0]      out_sign_extended,
  output logic [4:0]           out_rd,
  output logic                 out_uncond_branch,
  output logic                 out_branch,
  output logic                 out_mem_read,
  output logic                 out_mem_to_reg,
  output logic                 out_mem_write,
  output logic                 out_ALU_src,
  output logic                 out_reg_write,
  output logic [1:0]           out_ALU_op
);

  localparam logic [4:0] XZR_FIELD = 5'(xzr_idx(NUM_REGS));

  op_class_e       cls_c;
  ctrl_t           ctrl_c;
  logic [4:0]      rn_c, r2_c;
  logic [WORD-1:0] imm_c, rd1_c, rd2_c;
  logic            adv_c, stall_c;

  logic            valid_q, valid_d;
  logic [10:0]     opcode_q, opcode_d;
  logic [WORD-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;

  // Combinational decode of the offered instruction.
  always_comb begin
    cls_c  = op_class(in_instr[31:21]);
    ctrl_c = '0;
    imm_c  = '0;
    rn_c   = in_instr[9:5];
    r2_c   = in_instr[20:16];
    case (cls_c)
      CLS_RTYPE: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_RTYPE;
      end
      CLS_LDUR: begin
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_op     = ALU_LDST;
        imm_c = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end
      CLS_STUR: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_op    = ALU_LDST;
        r2_c  = in_instr[4:0];
        imm_c = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end
      CLS_CBZ: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_CBZ;
        r2_c  = in_instr[4:0];
        imm_c = {{(WORD-19){in_instr[23]}}, in_instr[23:5]};
      end
      CLS_B: begin
        ctrl_c.uncond_branch = 1'b1;
        imm_c = {{(WORD-26){in_instr[25]}}, in_instr[25:0]};
      end
      default: ;
    endcase
  end

  regfile_2r1w #(.WORD(WORD), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wb_en),
    .wr_addr    (wb_addr),
    .wr_data    (wb_data),
    .rd_addr1   (AW'(rn_c)),
    .rd_addr2   (AW'(r2_c)),
    .rd_data1_c (rd1_c),
    .rd_data2_c (rd2_c)
  );

  assign adv_c   = !valid_q || out_ready;
  assign stall_c = valid_q && ctrl_q.mem_read && (rd_q != XZR_FIELD) && in_valid &&
                   (rn_c == rd_q || r2_c == rd_q);
  assign in_ready = adv_c && !stall_c && !flush;

  // ID/EX next state: flush, then load, then bubble, else hold.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d  = 1'b1;
      opcode_d = in_instr[31:21];
      pc_d     = in_pc;
      rd1_d    = rd1_c;
      rd2_d    = rd2_c;
      imm_d    = imm_c;
      rd_d     = in_instr[4:0];
      ctrl_d   = ctrl_c;
    end else if (adv_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_opcode        = opcode_q;
  assign out_pc            = pc_q;
  assign out_read_data1    = rd1_q;
  assign out_read_data2    = rd2_q;
  assign out_sign_extended = imm_q;
  assign out_rd            = rd_q;
  assign out_uncond_branch = ctrl_q.uncond_branch;
  assign out_branch        = ctrl_q.branch;
  assign out_mem_read      = ctrl_q.mem_read;
  assign out_mem_to_reg    = ctrl_q.mem_to_reg;
  assign out_mem_write     = ctrl_q.mem_write;
  assign out_ALU_src       = ctrl_q.alu_src;
  assign out_reg_write     = ctrl_q.reg_write;
  assign out_ALU_op        = ctrl_q.alu_op;

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Pipelined, parametrised LEGv8 instruction-decode stage. It replaces the dual-clock decode with a single-clock stage that has valid/ready handshakes on both sides and an internal register file with a write-back port. It also detects a load-use hazard against the instruction it currently holds. Sits between the fetch stage (input) and the execute stage (output). Its output register is the ID/EX pipeline register.

## Interface
- `WORD`, 64: register and immediate width (≥ 32).
- `INSTR_LEN`, 32: instruction width (fixed encoding fields assume 32).
- `NUM_REGS`, 32: register-file entries; index `NUM_REGS-1` is XZR.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: fetch offers `in_instr` / `in_pc`.
- `in_ready`  out  1: stage accepts this cycle.
- `in_instr`  in  INSTR_LEN: instruction word.
- `in_pc`  in  WORD: instruction PC.
- `flush`  in  1: synchronous kill of held and offered instruction.
- `wb_en`  in  1: register write enable.
- `wb_addr`  in  $clog2(NUM_REGS): write index.
- `wb_data`  in  WORD: write data.
- `out_valid`  out  1: ID/EX register holds a valid instruction.
- `out_ready`  in  1: execute consumes this cycle.
- `out_opcode`  out  11: `instr[31:21]`.
- `out_pc`  out  WORD: PC of the held instruction.
- `out_read_data1`, `out_read_data2`  out  WORD: register operands.
- `out_sign_extended`  out  WORD: immediate.
- `out_rd`  out  5: destination / Rt field `[4:0]`.
- `out_uncond_branch`, `out_branch`, `out_mem_read`, `out_mem_to_reg`, `out_mem_write`, `out_ALU_src`, `out_reg_write`  out  1: control signals.
- `out_ALU_op`  out  2: ALU operation class.

## Operation
- **Opcode classes** (first match wins):
  - B: `[31:26]`=6'h05.
  - CBZ: `[31:24]`=8'hB4.
  - LDUR: 11'h7C2.
  - STUR: 11'h7C0.
  - R-type: ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550.
  - Anything else: all controls 0.
- **Controls**:
  - R-type: `reg_write`=1, `ALU_op`=10.
  - LDUR: `ALU_src`, `mem_read`, `mem_to_reg`, `reg_write` = 1; `ALU_op`=00.
  - STUR: `ALU_src`, `mem_write` = 1; `ALU_op`=00.
  - CBZ: `branch`=1, `ALU_op`=01.
  - B: `uncond_branch`=1.
- **Register reads**:
  - Port 1 reads Rn `[9:5]`.
  - Port 2 reads `[4:0]` for STUR and CBZ, and `[20:16]` otherwise.
  - Index `NUM_REGS-1` always reads 0.
- **Sign extension** to WORD:
  - LDUR/STUR: `[20:12]` (9 bit).
  - CBZ: `[23:5]` (19 bit).
  - B: `[25:0]` (26 bit).
  - Others: 0.
- **Register file**:
  - Reset clears all entries to 0.
  - Written on the clock edge when `wb_en` is high.
  - Writes to XZR are ignored.
  - An out-of-range `wb_addr` is ignored.
- **Pipe advance**: `adv = !out_valid || out_ready`.
- **Load-use stall**: `stall = out_valid && out_mem_read && out_rd != XZR && in_valid && (Rn == out_rd || port-2 index == out_rd)`.
- `in_ready = adv && !stall && !flush`.
- **Next ID/EX state**:
  - `flush` has top priority: `out_valid`←0.
  - Else if `in_valid && in_ready`: load the decoded instruction, `out_valid`←1.
  - Else if `adv`: `out_valid`←0 (a bubble; also the case during a stall).
  - Else: hold everything.
- Operands are sampled at acceptance. They are never refreshed while held.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`. Throughput is 1 per cycle.
- A load-use hazard costs exactly one bubble once the load has been consumed.
- If `out_ready` is low, outputs hold stable. No output changes while `out_valid && !out_ready`.
- Reset: `out_valid`=0 and every `out_*` field is 0. `in_ready` follows combinationally (1 after reset).
- Reset asserted mid-operation discards the held instruction immediately (asynchronous) and clears the register file.
- `flush` together with `out_ready` in the same cycle: the held instruction is consumed, nothing new is loaded, and `out_valid`=0 next cycle.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: when `wb_en` is high and `wb_addr` equals a read index other than XZR, that read returns `wb_data` in the same cycle (write-before-read).
- Not defined: the read returns the pre-write register contents. The write is visible only to instructions accepted in later cycles.

## Structure
- Package `decode_pkg` holds:
  - Opcode constants.
  - `ALU_op` encodings (`ALU_LDST`=00, `ALU_CBZ`=01, `ALU_RTYPE`=10).
  - The opcode-class enum.
  - The XZR index function.
- One sub-module, `regfile_2r1w`: parametrised on `WORD` and `NUM_REGS`, asynchronous reads, contains the bypass macro logic.

## Test plan
- Reset, then write X22=100 via write-back. Offer 32'hF84402C9 → next cycle `out_opcode`=11'h7C2, `out_read_data1`=100, `out_sign_extended`=64, `out_rd`=9, `mem_read`=`mem_to_reg`=`ALU_src`=`reg_write`=1.
- LDUR above held, offer 32'h8B09026A (ADD X10,X19,X9), `out_ready`=1 → `in_ready`=0 for one cycle, one bubble (`out_valid`=0), ADD accepted the following cycle with `ALU_op`=10.
- Offer 32'hB4FFFF6B → `out_branch`=1, `out_sign_extended`=64'hFFFF_FFFF_FFFF_FFFB, port 2 reads X11. Offer 32'h17FFFFC9 → `out_uncond_branch`=1, immediate 64'hFFFF_FFFF_FFFF_FFC9.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → outputs frozen, `in_ready`=0. Then assert `flush` → `out_valid`=0 next cycle, offered instruction not accepted.
- Offer 32'hAA150149 (ORR X9,X10,X21) with `wb_en`=1, `wb_addr`=21, `wb_data`=30, X21 previously 5:
  - Macro defined: `out_read_data2`=30.
  - Macro undefined: `out_read_data2`=5.
  - Separately, `wb_addr`=31 with data 7: X31 still reads 0.
- Assert `rst_n`=0 while `out_valid`=1 → `out_valid` and all outputs 0 immediately, register file reads 0 after release.
